// File: rtl/pc_stack_unit.sv
// pc_stack_unit
// Program counter with a hardware call/return stack, skip support and
// explicit branch loading. The counter drives the ROM address; ops come
// from decode and take effect on the next rising clock edge.
//
// Optional build macro: PC_STACK_GUARD_EN
//   undefined (default): the stack is a true circular buffer. A CALL on a
//     full stack overwrites the oldest entry. A RET on an empty stack
//     returns whatever stale entry sits below the pointer.
//   defined: a CALL on a full stack drops the push. A RET on an empty stack
//     returns to RESET_VECTOR and leaves the pointer alone.
// In both builds, overflow and underflow are sticky until reset.

module pc_stack_unit #(
  parameter int PC_WIDTH     = 11,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         op_valid,
  input  logic [2:0]                   op,
  input  logic [PC_WIDTH-1:0]          target,
  output logic [PC_WIDTH-1:0]          counter,
  output logic [PC_WIDTH-1:0]          tos,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  localparam logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_VECTOR);
  localparam logic [DEPTH_W-1:0]  FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  // Op encoding as seen on the decode interface; 6 and 7 fall into default.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_SKIP = 3'd2,
    OP_JUMP = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } op_e;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_next;
  logic [PTR_W-1:0]    ptr_dec;
  logic [PC_WIDTH-1:0] counter_next;
  logic [PC_WIDTH-1:0] return_addr;
  logic [PC_WIDTH-1:0] below_ptr;
  logic [DEPTH_W-1:0]  depth_next;
  logic                overflow_next;
  logic                underflow_next;
  logic                push_en;

  // The pointer addresses the next free slot, so the top entry is one below.
  // The decrement wraps, which is what lets an empty-stack RET reach stale data.
  assign ptr_dec     = ptr - PTR_W'(1);
  assign below_ptr   = stack_mem[ptr_dec];
  assign return_addr = counter + PC_WIDTH'(1);

  assign stack_full  = (depth == FULL_DEPTH);
  assign stack_empty = (depth == '0);
  assign tos         = stack_empty ? '0 : below_ptr;

  // Next-state selection for the counter, the stack pointer, the depth and the sticky flags.
  always_comb begin
    counter_next   = counter;
    ptr_next       = ptr;
    depth_next     = depth;
    overflow_next  = overflow;
    underflow_next = underflow;
    push_en        = 1'b0;

    if (op_valid) begin
      case (op)
        OP_HOLD: begin
        end
        OP_INC: begin
          counter_next = counter + PC_WIDTH'(1);
        end
        OP_SKIP: begin
          counter_next = counter + PC_WIDTH'(2);
        end
        OP_JUMP: begin
          counter_next = target;
        end
        OP_CALL: begin
          counter_next = target;
          if (stack_full) begin
            overflow_next = 1'b1;
`ifndef PC_STACK_GUARD_EN
            push_en  = 1'b1;
            ptr_next = ptr + PTR_W'(1);
`endif
          end else begin
            push_en    = 1'b1;
            ptr_next   = ptr + PTR_W'(1);
            depth_next = depth + DEPTH_W'(1);
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            underflow_next = 1'b1;
`ifdef PC_STACK_GUARD_EN
            counter_next = RESET_PC;
`else
            counter_next = below_ptr;
            ptr_next     = ptr_dec;
`endif
          end else begin
            counter_next = below_ptr;
            ptr_next     = ptr_dec;
            depth_next   = depth - DEPTH_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural state register. Reset discards any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter   <= RESET_PC;
      ptr       <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      counter   <= counter_next;
      ptr       <= ptr_next;
      depth     <= depth_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

  // Return-address storage. It is cleared on reset so that stale reads are deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else if (push_en) begin
      stack_mem[ptr] <= return_addr;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit
// Scoreboard bench for pc_stack_unit. The driver applies ops on the falling
// edge and queues the state a reference model predicts. The monitor pops one
// expectation just after each rising edge and compares it.
// The model tracks the stack as an array of return addresses with a wrapping
// index. Build with PC_STACK_GUARD_EN to check the guarded variant.

module tb_pc_stack_unit;

  localparam int PCW    = 11;
  localparam int SD     = 8;
  localparam int DW     = $clog2(SD) + 1;
  localparam int RV     = 0;
  localparam int PCMASK = (1 << PCW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_valid;
  logic [2:0]     op;
  logic [PCW-1:0] target;
  logic [PCW-1:0] counter;
  logic [PCW-1:0] tos;
  logic [DW-1:0]  depth;
  logic           stack_full;
  logic           stack_empty;
  logic           overflow;
  logic           underflow;

  pc_stack_unit #(
    .PC_WIDTH(PCW),
    .STACK_DEPTH(SD),
    .RESET_VECTOR(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .op_valid(op_valid),
    .op(op),
    .target(target),
    .counter(counter),
    .tos(tos),
    .depth(depth),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int counter;
    int tos;
    int depth;
    bit full;
    bit empty;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;

  // Reference model: program counter plus a return-address ring.
  int m_counter;
  int m_ptr;
  int m_depth;
  int m_mem[SD];
  bit m_ovf;
  bit m_unf;

  function automatic void model_reset();
    m_counter = RV;
    m_ptr     = 0;
    m_depth   = 0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    for (int i = 0; i < SD; i++) m_mem[i] = 0;
  endfunction

  function automatic void model_step(input bit v, input int o, input int t);
    if (!v) return;
    case (o)
      1: m_counter = (m_counter + 1) & PCMASK;
      2: m_counter = (m_counter + 2) & PCMASK;
      3: m_counter = t;
      4: begin
        if (m_depth == SD) begin
          m_ovf = 1'b1;
`ifndef PC_STACK_GUARD_EN
          m_mem[m_ptr] = (m_counter + 1) & PCMASK;
          m_ptr = (m_ptr + 1) % SD;
`endif
        end else begin
          m_mem[m_ptr] = (m_counter + 1) & PCMASK;
          m_ptr = (m_ptr + 1) % SD;
          m_depth++;
        end
        m_counter = t;
      end
      5: begin
        if (m_depth == 0) begin
          m_unf = 1'b1;
`ifdef PC_STACK_GUARD_EN
          m_counter = RV;
`else
          m_ptr = (m_ptr + SD - 1) % SD;
          m_counter = m_mem[m_ptr];
`endif
        end else begin
          m_ptr = (m_ptr + SD - 1) % SD;
          m_counter = m_mem[m_ptr];
          m_depth--;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    tag_cnt++;
    e.tag     = tag_cnt;
    e.counter = m_counter;
    e.tos     = (m_depth == 0) ? 0 : m_mem[(m_ptr + SD - 1) % SD];
    e.depth   = m_depth;
    e.full    = (m_depth == SD);
    e.empty   = (m_depth == 0);
    e.ovf     = m_ovf;
    e.unf     = m_unf;
    return e;
  endfunction

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_val($sformatf("counter#%0d", e.tag), 32'(counter), e.counter);
    check_val($sformatf("tos#%0d", e.tag), 32'(tos), e.tos);
    check_val($sformatf("depth#%0d", e.tag), 32'(depth), e.depth);
    check_val($sformatf("full#%0d", e.tag), 32'(stack_full), 32'(e.full));
    check_val($sformatf("empty#%0d", e.tag), 32'(stack_empty), 32'(e.empty));
    check_val($sformatf("overflow#%0d", e.tag), 32'(overflow), 32'(e.ovf));
    check_val($sformatf("underflow#%0d", e.tag), 32'(underflow), 32'(e.unf));
  endtask

  // Reset values must be visible immediately, without a clock edge.
  task automatic check_reset_state(input string name);
    check_val({name, "_counter"}, 32'(counter), RV);
    check_val({name, "_depth"}, 32'(depth), 0);
    check_val({name, "_tos"}, 32'(tos), 0);
    check_val({name, "_empty"}, 32'(stack_empty), 1);
    check_val({name, "_flags"}, 32'({overflow, underflow}), 0);
  endtask

  // Drives an op at the current time and queues the predicted post-edge state.
  task automatic drive_now(input bit v, input int o, input int t);
    op_valid = v;
    op       = 3'(o);
    target   = PCW'(t);
    model_step(v, o, t & PCMASK);
    exp_q.push_back(model_snapshot());
  endtask

  task automatic apply_stimulus(input bit v, input int o, input int t);
    @(negedge clk);
    drive_now(v, o, t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    op_valid = 1'b0;
    reset    = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: one expectation per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  // Watchdog so that the run always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int o;
    reset    = 1'b0;
    op_valid = 1'b0;
    op       = 3'd0;
    target   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("por");
    reset = 1'b1;

    // 1: five increments from reset
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1, 0);

    // 2: wrap behaviour of INC and SKIP at the top of the address space
    apply_stimulus(1'b1, 3, 'h7FE);
    apply_stimulus(1'b1, 1, 0);
    apply_stimulus(1'b1, 1, 0);
    apply_stimulus(1'b1, 3, 'h7FE);
    apply_stimulus(1'b1, 2, 0);
    apply_stimulus(1'b1, 3, 'h7FF);
    apply_stimulus(1'b1, 2, 0);

    // 3: a simple call and return
    apply_stimulus(1'b1, 3, 'h010);
    apply_stimulus(1'b1, 4, 'h200);
    apply_stimulus(1'b1, 1, 0);
    apply_stimulus(1'b1, 1, 0);
    apply_stimulus(1'b0, 5, 0);
    apply_stimulus(1'b1, 5, 0);

    // 4: nine nested calls followed by eight returns
    do_reset();
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 4, 'h100 + i);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 5, 0);

    // 5: a return on an empty stack directly after reset
    do_reset();
    apply_stimulus(1'b1, 5, 0);
    apply_stimulus(1'b1, 6, 'h123);
    apply_stimulus(1'b1, 7, 'h321);

    // 6: reset asserted partway through a CALL cycle
    @(negedge clk);
    op_valid = 1'b1;
    op       = 3'd4;
    target   = PCW'('h3AA);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    reset = 1'b1;
    drive_now(1'b1, 3, 'h055);

    // Randomized ops, with an occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 127) == 0) do_reset();
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2, 3: o = 1;
        4, 15:      o = 2;
        5:          o = 3;
        6, 7, 8:    o = 4;
        9, 10, 11:  o = 5;
        12:         o = 0;
        13:         o = 6;
        default:    o = 7;
      endcase
      apply_stimulus($urandom_range(0, 9) != 0, o, int'($urandom) & PCMASK);
    end

    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
